// File: rtl/uart_rx_deserializer_if.sv
// Receive-side UART bundle: raw serial line and enable in, recovered byte and status pulses out.
interface uart_rx_deserializer_if #(
  parameter int PAYLOAD_BITS = 8
);
  logic                    uart_rxd;
  logic                    uart_rx_en;
  logic [PAYLOAD_BITS-1:0] uart_rx_data;
  logic                    uart_rx_valid;
  logic                    uart_rx_frame_err;
  logic                    uart_rx_break;

  modport master (
    output uart_rxd,
    output uart_rx_en,
    input  uart_rx_data,
    input  uart_rx_valid,
    input  uart_rx_frame_err,
    input  uart_rx_break
  );

  modport slave (
    input  uart_rxd,
    input  uart_rx_en,
    output uart_rx_data,
    output uart_rx_valid,
    output uart_rx_frame_err,
    output uart_rx_break
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// 8N1-style UART receiver: synchronises the line, detects a falling start edge,
// samples every bit at mid-period and emits byte/valid, framing-error and break pulses.
module uart_rx_deserializer #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_rx_deserializer_if.slave bus
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CNT_W          = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int IDX_W          = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                  r_state;
  state_t                  w_stateNext;
  logic                    r_sync1;
  logic                    r_sync2;
  logic                    r_prevLine;
  logic [CNT_W-1:0]        r_cycleCnt;
  logic [CNT_W-1:0]        w_cycleCntNext;
  logic [IDX_W-1:0]        r_bitIdx;
  logic [IDX_W-1:0]        w_bitIdxNext;
  logic [PAYLOAD_BITS-1:0] r_shift;
  logic [PAYLOAD_BITS-1:0] w_shiftNext;
  logic [PAYLOAD_BITS-1:0] r_data;
  logic [PAYLOAD_BITS-1:0] w_dataNext;
  logic                    r_valid;
  logic                    w_validNext;
  logic                    r_frameErr;
  logic                    w_frameErrNext;
  logic                    r_break;
  logic                    w_breakNext;
  logic                    w_startEdge;

  // A start is only a genuine 1->0 transition, so a line stuck low never retriggers.
  assign w_startEdge = r_prevLine & ~r_sync2;

  // Two-flop synchroniser plus a history flop; all idle high so reset never fakes an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_prevLine <= 1'b1;
    end else begin
      r_sync1    <= bus.uart_rxd;
      r_sync2    <= r_sync1;
      r_prevLine <= r_sync2;
    end
  end

  // Frame state, counters, shift register and registered output pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cycleCnt <= '0;
      r_bitIdx   <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
      r_break    <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_cycleCnt <= w_cycleCntNext;
      r_bitIdx   <= w_bitIdxNext;
      r_shift    <= w_shiftNext;
      r_data     <= w_dataNext;
      r_valid    <= w_validNext;
      r_frameErr <= w_frameErrNext;
      r_break    <= w_breakNext;
    end
  end

  // Next-state logic: half-bit start check, then one sample per full bit period.
  always_comb begin
    w_stateNext    = r_state;
    w_cycleCntNext = r_cycleCnt;
    w_bitIdxNext   = r_bitIdx;
    w_shiftNext    = r_shift;
    w_dataNext     = r_data;
    w_validNext    = 1'b0;
    w_frameErrNext = 1'b0;
    w_breakNext    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_startEdge && bus.uart_rx_en) begin
          w_stateNext    = S_START;
          w_cycleCntNext = '0;
        end
      end

      S_START: begin
        if (r_cycleCnt == CNT_W'(HALF_BIT - 1)) begin
          w_cycleCntNext = '0;
          if (!r_sync2) begin
            w_stateNext  = S_DATA;
            w_bitIdxNext = '0;
          end else begin
            w_stateNext = S_IDLE;
          end
        end else begin
          w_cycleCntNext = r_cycleCnt + 1'b1;
        end
      end

      S_DATA: begin
        if (r_cycleCnt == CNT_W'(CYCLES_PER_BIT - 1)) begin
          w_cycleCntNext = '0;
          w_shiftNext    = {r_sync2, r_shift[PAYLOAD_BITS-1:1]};
          if (r_bitIdx == IDX_W'(PAYLOAD_BITS - 1)) begin
            w_stateNext = S_STOP;
          end else begin
            w_bitIdxNext = r_bitIdx + 1'b1;
          end
        end else begin
          w_cycleCntNext = r_cycleCnt + 1'b1;
        end
      end

      S_STOP: begin
        if (r_cycleCnt == CNT_W'(CYCLES_PER_BIT - 1)) begin
          w_cycleCntNext = '0;
          w_stateNext    = S_IDLE;
          if (r_sync2) begin
            w_dataNext  = r_shift;
            w_validNext = 1'b1;
          end else begin
            w_frameErrNext = 1'b1;
            w_breakNext    = (r_shift == '0);
          end
        end else begin
          w_cycleCntNext = r_cycleCnt + 1'b1;
        end
      end

      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  assign bus.uart_rx_data      = r_data;
  assign bus.uart_rx_valid     = r_valid;
  assign bus.uart_rx_frame_err = r_frameErr;
  assign bus.uart_rx_break     = r_break;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer at 10 clocks per bit: each driven frame
// queues its expected pulse, a monitor pops and compares whenever the receiver pulses.
module tb_uart_rx_deserializer;

  localparam int CPB = 10;
  localparam int LATENCY = 98;

  typedef struct {
    logic [2:0] flags;
    logic [7:0] data;
    int         fallCyc;
  } expItem_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  logic [7:0] lastData;
  expItem_t   expQ[$];

  uart_rx_deserializer_if #(.PAYLOAD_BITS(8)) bus();

  uart_rx_deserializer #(
    .CLK_HZ      (1_000_000),
    .BIT_RATE    (100_000),
    .PAYLOAD_BITS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame starting now (caller sits just after a rising edge) and queues the expected result.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input bit expectPulse);
    expItem_t item;
    bus.uart_rxd = 1'b0;
    if (expectPulse) begin
      item.fallCyc = cyc;
      if (stopBit) begin
        item.flags = 3'b100;
        item.data  = b;
        lastData   = b;
      end else begin
        item.flags = {1'b0, 1'b1, (b == 8'h00)};
        item.data  = lastData;
      end
      expQ.push_back(item);
    end
    waitCycles(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rxd = b[i];
      waitCycles(CPB);
    end
    bus.uart_rxd = stopBit;
    waitCycles(CPB);
    bus.uart_rxd = 1'b1;
  endtask

  // Monitor: every receiver pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    expItem_t item;
    if (rst && (bus.uart_rx_valid || bus.uart_rx_frame_err || bus.uart_rx_break)) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_pulse",
                    {29'd0, bus.uart_rx_valid, bus.uart_rx_frame_err, bus.uart_rx_break}, 32'd0);
      end else begin
        item = expQ.pop_front();
        checkOutput("pulse_flags",
                    {29'd0, bus.uart_rx_valid, bus.uart_rx_frame_err, bus.uart_rx_break},
                    {29'd0, item.flags});
        checkOutput("rx_data", {24'd0, bus.uart_rx_data}, {24'd0, item.data});
        checkOutput("latency", cyc - item.fallCyc, LATENCY);
      end
    end
  end

  // Main sequence of scenarios.
  initial begin
    rst          = 1'b0;
    bus.uart_rxd = 1'b1;
    bus.uart_rx_en = 1'b1;
    lastData     = 8'h00;
    checks       = 0;
    errors       = 0;
    waitCycles(3);
    checkOutput("reset_data",  {24'd0, bus.uart_rx_data}, 32'd0);
    checkOutput("reset_valid", {31'd0, bus.uart_rx_valid}, 32'd0);
    checkOutput("reset_ferr",  {31'd0, bus.uart_rx_frame_err}, 32'd0);
    checkOutput("reset_break", {31'd0, bus.uart_rx_break}, 32'd0);
    rst = 1'b1;
    waitCycles(5);

    $display("[TB] single frame 0xA5");
    applyStimulus(8'hA5, 1'b1, 1'b1);
    waitCycles(20);

    $display("[TB] back-to-back 0x3C, 0xC3");
    applyStimulus(8'h3C, 1'b1, 1'b1);
    applyStimulus(8'hC3, 1'b1, 1'b1);
    waitCycles(20);

    $display("[TB] framing error on 0x55");
    applyStimulus(8'h55, 1'b0, 1'b1);
    waitCycles(20);
    checkOutput("data_hold_after_ferr", {24'd0, bus.uart_rx_data}, 32'h0000_00C3);

    $display("[TB] line break");
    begin
      expItem_t item;
      bus.uart_rxd = 1'b0;
      item.fallCyc = cyc;
      item.flags   = 3'b011;
      item.data    = lastData;
      expQ.push_back(item);
      waitCycles(150);
      bus.uart_rxd = 1'b1;
      waitCycles(30);
    end
    checkOutput("break_drained", expQ.size(), 32'd0);

    $display("[TB] short glitch then 0x81");
    bus.uart_rxd = 1'b0;
    waitCycles(3);
    bus.uart_rxd = 1'b1;
    waitCycles(30);
    applyStimulus(8'h81, 1'b1, 1'b1);
    waitCycles(20);

    $display("[TB] reset during data bit 4, then 0x7E");
    bus.uart_rxd = 1'b0;
    waitCycles(CPB);
    for (int i = 0; i < 4; i++) begin
      bus.uart_rxd = i[0];
      waitCycles(CPB);
    end
    bus.uart_rxd = 1'b1;
    waitCycles(5);
    rst = 1'b0;
    #2;
    checkOutput("midreset_data",  {24'd0, bus.uart_rx_data}, 32'd0);
    checkOutput("midreset_valid", {31'd0, bus.uart_rx_valid}, 32'd0);
    checkOutput("midreset_ferr",  {31'd0, bus.uart_rx_frame_err}, 32'd0);
    checkOutput("midreset_break", {31'd0, bus.uart_rx_break}, 32'd0);
    lastData = 8'h00;
    waitCycles(5);
    rst = 1'b1;
    waitCycles(20);
    applyStimulus(8'h7E, 1'b1, 1'b1);
    waitCycles(20);

    $display("[TB] receiver disabled, 0x12");
    bus.uart_rx_en = 1'b0;
    applyStimulus(8'h12, 1'b1, 1'b0);
    waitCycles(20);
    bus.uart_rx_en = 1'b1;
    checkOutput("data_after_disabled", {24'd0, bus.uart_rx_data}, 32'h0000_007E);

    waitCycles(50);
    checkOutput("pending_expectations", expQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Serial-to-parallel UART receive stage that sits directly upstream of the SSD display and loopback logic. It recovers 8N1 frames from the asynchronous `uart_rxd` pin, samples each bit at mid-period, and presents each byte on `uart_rx_data` with a one-cycle `uart_rx_valid` strobe. It also flags framing errors and line breaks so the display can fall back to showing a dash.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency in Hz.
- `BIT_RATE`, default 9600: line rate in baud.
- `PAYLOAD_BITS`, default 8: data bits per frame, sent LSB first.
- Derived constants:
  - `CYCLES_PER_BIT = CLK_HZ / BIT_RATE`, integer division, truncated. The default is 5208.
  - `HALF_BIT = CYCLES_PER_BIT / 2`, truncated. The default is 2604.
  - Counter width is `$clog2(CYCLES_PER_BIT)`.
- `clk  input  1`: system clock; all logic is on the rising edge.
- `rst  input  1`: asynchronous, active-low reset.
- `uart_rxd  input  1`: raw serial line. It idles high and is asynchronous to `clk`.
- `uart_rx_en  input  1`: when high, new frames may start.
- `uart_rx_data  output  PAYLOAD_BITS`: last correctly framed byte.
- `uart_rx_valid  output  1`: one-cycle pulse when `uart_rx_data` updates.
- `uart_rx_frame_err  output  1`: one-cycle pulse when the stop bit is sampled low.
- `uart_rx_break  output  1`: one-cycle pulse when all data bits and the stop bit are 0.

## Operation
- Input synchronisation:
  - `uart_rxd` passes through a 2-FF synchronizer. Both flops reset to 1.
  - A third register holds the previous synchronised value, also reset to 1.
  - A start edge is defined as previous = 1 and synchronised = 0.
- Reset values: state = IDLE, counters = 0, shift register = 0, `uart_rx_data` = 0. `uart_rx_valid`, `uart_rx_frame_err` and `uart_rx_break` are all 0.
- **IDLE**
  - Go to START when a start edge is seen and `uart_rx_en` = 1. Clear the cycle counter.
  - A line that is held low never retriggers. A new start needs a 1→0 transition.
- **START**
  - Count to `HALF_BIT - 1`.
  - At that point, if the synchronised line is still 0, go to DATA and clear both the cycle counter and the bit index.
  - If the line is 1, treat it as a glitch and return to IDLE with no pulse.
- **DATA**
  - Count `CYCLES_PER_BIT - 1` cycles, then sample.
  - Shift the sampled bit in at the MSB side and shift right, so the first received bit ends in bit 0.
  - After `PAYLOAD_BITS` samples, go to STOP.
- **STOP**
  - After `CYCLES_PER_BIT - 1` cycles, sample the stop bit.
  - If the stop bit is 1: load the shift register into `uart_rx_data` and pulse `uart_rx_valid`.
  - If the stop bit is 0: pulse `uart_rx_frame_err`, and leave `uart_rx_data` unchanged. If the shift register is also all zero, pulse `uart_rx_break` in the same cycle.
  - Return to IDLE in all cases.
- `uart_rx_en` is only checked in IDLE. Deasserting it mid-frame lets the current frame finish normally.
- At most one of `uart_rx_valid` and `uart_rx_frame_err` is high in any cycle. `uart_rx_break` is only ever high together with `uart_rx_frame_err`.
- `uart_rx_data` holds its value between frames. Downstream logic may read it at any time.

## Timing
- Let t0 be the cycle in which the start edge is registered. This is 2–3 cycles after the pin falls, depending on synchronizer phase.
- Start-bit check occurs at t0 + `HALF_BIT`.
- Data bit k (k = 0..`PAYLOAD_BITS`-1) is sampled at t0 + `HALF_BIT` + (k+1)·`CYCLES_PER_BIT`.
- The stop bit is sampled at t0 + `HALF_BIT` + (`PAYLOAD_BITS`+1)·`CYCLES_PER_BIT`.
- The output pulses and the `uart_rx_data` update are registered on that sampling edge and are visible for exactly the following cycle.
- IDLE is re-entered on the same edge. A start edge arriving one cycle later is accepted, so back-to-back frames with zero idle gap are supported.
- Asserting `rst` mid-frame discards the partial frame immediately (asynchronously) and produces no pulse. After release, the line must go high and then low before a new frame starts.
- Tolerance: sampling at mid-bit absorbs up to ±4% total baud mismatch across a 10-bit frame.

## Test plan
Bench parameters: `CLK_HZ` = 1_000_000 and `BIT_RATE` = 100_000, giving `CYCLES_PER_BIT` = 10 and `HALF_BIT` = 5.

- Send byte 0xA5 with a good stop bit → one `uart_rx_valid` pulse 2–3 + 5 + 90 cycles after the pin falls. `uart_rx_data` = 0xA5. No error pulses.
- Send 0x3C then 0xC3 with zero idle gap → two `uart_rx_valid` pulses, 100 cycles apart, showing 0x3C then 0xC3.
- Send 0x55 with the stop bit driven low → `uart_rx_frame_err` pulse. No `uart_rx_valid`. `uart_rx_data` keeps its previous value.
- Hold the line low for 150 cycles, then release → `uart_rx_frame_err` and `uart_rx_break` pulse together once. There is no retrigger until a new 1→0 edge.
- Drive a 3-cycle low glitch → return to IDLE at the start check with no pulses. A valid 0x81 frame sent afterwards is received correctly.
- Assert `rst` low during data bit 4 of a frame, then release with the line high → all outputs are 0. The next 0x7E frame is received correctly.
- Hold `uart_rx_en` = 0 and send 0x12 → no pulses.
